// File: rtl/ttc_lite_pkg18.sv
// Shared definitions for the lite triple-timer counter APB front-end.
// Holds the word offsets of the register map (paddr[7:2]), the APB
// front-end FSM state encoding, and the read-only attribute helper.
package ttc_lite_pkg18;

  localparam logic [5:0] OFF_CLK_CTRL    = 6'h00;
  localparam logic [5:0] OFF_CNTR_CTRL   = 6'h01;
  localparam logic [5:0] OFF_COUNTER_VAL = 6'h02;
  localparam logic [5:0] OFF_INTERVAL    = 6'h03;
  localparam logic [5:0] OFF_MATCH_1     = 6'h04;
  localparam logic [5:0] OFF_MATCH_2     = 6'h05;
  localparam logic [5:0] OFF_MATCH_3     = 6'h06;
  localparam logic [5:0] OFF_INTR_STAT   = 6'h07;
  localparam logic [5:0] OFF_INTR_EN     = 6'h08;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WR_ACC,
    ST_RD_WAIT,
    ST_RD_DONE
  } apb_state_e;

  // Counter value and interrupt status are owned by the counter block;
  // software can only read them.
  function automatic logic reg_is_ro(input logic [5:0] off);
    return (off == OFF_COUNTER_VAL) || (off == OFF_INTR_STAT);
  endfunction

endpackage

// File: rtl/ttc_apb_rdmux_lite18.sv
// Combinational readback mux for the lite timer-counter register map.
// Ports:
//   reg_off            word offset (paddr[7:2])
//   *_reg18            register readback values from the counter block
//   rd_data            selected register, zero-extended to 32 bits (0 if unmapped)
//   reg_mapped         offset decodes to a register
//   reg_ro             offset decodes to a read-only register
module ttc_apb_rdmux_lite18
  import ttc_lite_pkg18::*;
(
  input  logic [5:0]  reg_off,
  input  logic [6:0]  clk_ctrl_reg18,
  input  logic [6:0]  cntr_ctrl_reg18,
  input  logic [15:0] counter_val_reg18,
  input  logic [15:0] interval_reg18,
  input  logic [15:0] match_1_reg18,
  input  logic [15:0] match_2_reg18,
  input  logic [15:0] match_3_reg18,
  input  logic [5:0]  interrupt_reg18,
  input  logic [5:0]  interrupt_en_reg18,
  output logic [31:0] rd_data,
  output logic        reg_mapped,
  output logic        reg_ro
);

  always_comb begin
    rd_data    = '0;
    reg_mapped = 1'b1;
    case (reg_off)
      OFF_CLK_CTRL:    rd_data = {25'd0, clk_ctrl_reg18};
      OFF_CNTR_CTRL:   rd_data = {25'd0, cntr_ctrl_reg18};
      OFF_COUNTER_VAL: rd_data = {16'd0, counter_val_reg18};
      OFF_INTERVAL:    rd_data = {16'd0, interval_reg18};
      OFF_MATCH_1:     rd_data = {16'd0, match_1_reg18};
      OFF_MATCH_2:     rd_data = {16'd0, match_2_reg18};
      OFF_MATCH_3:     rd_data = {16'd0, match_3_reg18};
      OFF_INTR_STAT:   rd_data = {26'd0, interrupt_reg18};
      OFF_INTR_EN:     rd_data = {26'd0, interrupt_en_reg18};
      default:         reg_mapped = 1'b0;
    endcase
    reg_ro = reg_mapped & reg_is_ro(reg_off);
  end

endmodule

// File: rtl/ttc_apb_if_lite18.sv
// APB3 slave front-end for the single-channel lite triple-timer counter.
// Turns APB transfers into one-cycle register write strobes with registered
// write data, returns registered read data from the counter block and
// generates the clear-on-read pulse for the interrupt status register.
// Ports:
//   pclk18, p_reset18           clock, synchronous active-high reset
//   psel18..pwdata18            APB3 request
//   prdata18, pready18,
//   pslverr18                   APB3 response (registered)
//   pwdata_out18                registered write data to the counter block
//   *_reg_sel18                 one-cycle write strobes, aligned with pready18
//   clear_interrupt18           interrupt status clear, aligned with pready18
//   *_reg18 inputs              register readback from the counter block
module ttc_apb_if_lite18
  import ttc_lite_pkg18::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic        pclk18,
  input  logic        p_reset18,
  input  logic        psel18,
  input  logic        penable18,
  input  logic        pwrite18,
  input  logic [7:0]  paddr18,
  input  logic [31:0] pwdata18,
  output logic [31:0] prdata18,
  output logic        pready18,
  output logic        pslverr18,
  output logic [15:0] pwdata_out18,
  output logic        clk_ctrl_reg_sel18,
  output logic        cntr_ctrl_reg_sel18,
  output logic        interval_reg_sel18,
  output logic        match_1_reg_sel18,
  output logic        match_2_reg_sel18,
  output logic        match_3_reg_sel18,
  output logic        intr_en_reg_sel18,
  output logic        clear_interrupt18,
  input  logic [6:0]  clk_ctrl_reg18,
  input  logic [6:0]  cntr_ctrl_reg18,
  input  logic [15:0] counter_val_reg18,
  input  logic [15:0] interval_reg18,
  input  logic [15:0] match_1_reg18,
  input  logic [15:0] match_2_reg18,
  input  logic [15:0] match_3_reg18,
  input  logic [5:0]  interrupt_reg18,
  input  logic [5:0]  interrupt_en_reg18
);

  localparam logic [1:0] WAIT_LOAD = 2'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

  apb_state_e  state;
  logic [1:0]  rd_cnt;
  logic [6:0]  strb_p1;
  logic [6:0]  wr_strb;
  logic [5:0]  reg_off;
  logic [31:0] rd_data;
  logic        reg_mapped;
  logic        reg_ro;
  logic        wr_ok;
  logic        is_stat;
  logic        xfer_abort;
  logic        unused_bits;

  // Byte-lane bits of the address and the upper write-data half are unused.
  assign unused_bits = ^{paddr18[1:0], pwdata18[31:16]};

  assign reg_off    = paddr18[7:2];
  assign wr_ok      = reg_mapped & ~reg_ro;
  assign is_stat    = (reg_off == OFF_INTR_STAT);
  assign xfer_abort = ~psel18 | ~penable18;

  ttc_apb_rdmux_lite18 u_rdmux (
    .reg_off            (reg_off),
    .clk_ctrl_reg18     (clk_ctrl_reg18),
    .cntr_ctrl_reg18    (cntr_ctrl_reg18),
    .counter_val_reg18  (counter_val_reg18),
    .interval_reg18     (interval_reg18),
    .match_1_reg18      (match_1_reg18),
    .match_2_reg18      (match_2_reg18),
    .match_3_reg18      (match_3_reg18),
    .interrupt_reg18    (interrupt_reg18),
    .interrupt_en_reg18 (interrupt_en_reg18),
    .rd_data            (rd_data),
    .reg_mapped         (reg_mapped),
    .reg_ro             (reg_ro)
  );

  // One-hot write strobe for the writable registers; RO/unmapped give zero.
  always_comb begin
    wr_strb = '0;
    case (reg_off)
      OFF_CLK_CTRL:  wr_strb[0] = 1'b1;
      OFF_CNTR_CTRL: wr_strb[1] = 1'b1;
      OFF_INTERVAL:  wr_strb[2] = 1'b1;
      OFF_MATCH_1:   wr_strb[3] = 1'b1;
      OFF_MATCH_2:   wr_strb[4] = 1'b1;
      OFF_MATCH_3:   wr_strb[5] = 1'b1;
      OFF_INTR_EN:   wr_strb[6] = 1'b1;
      default:       wr_strb = '0;
    endcase
  end

  // Response outputs default to zero every cycle so each is a one-cycle pulse
  // on the completion edge; prdata18 is thereby cleared after RD_DONE.
  always_ff @(posedge pclk18) begin
    if (p_reset18) begin
      state             <= ST_IDLE;
      rd_cnt            <= '0;
      prdata18          <= '0;
      pready18          <= 1'b0;
      pslverr18         <= 1'b0;
      pwdata_out18      <= '0;
      strb_p1           <= '0;
      clear_interrupt18 <= 1'b0;
    end else begin
      prdata18          <= '0;
      pready18          <= 1'b0;
      pslverr18         <= 1'b0;
      strb_p1           <= '0;
      clear_interrupt18 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (psel18 && !penable18) state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (xfer_abort) begin
            state <= ST_IDLE;
          end else if (pwrite18) begin
            state        <= ST_WR_ACC;
            pready18     <= 1'b1;
            pwdata_out18 <= pwdata18[15:0];
            if (wr_ok) strb_p1 <= wr_strb;
            else       pslverr18 <= 1'b1;
          end else if (RD_WAIT > 0) begin
            state  <= ST_RD_WAIT;
            rd_cnt <= WAIT_LOAD;
          end else begin
            state             <= ST_RD_DONE;
            pready18          <= 1'b1;
            prdata18          <= rd_data;
            pslverr18         <= ~reg_mapped;
            clear_interrupt18 <= is_stat;
          end
        end
        ST_RD_WAIT: begin
          if (xfer_abort) begin
            state <= ST_IDLE;
          end else if (rd_cnt == 2'd0) begin
            state             <= ST_RD_DONE;
            pready18          <= 1'b1;
            prdata18          <= rd_data;
            pslverr18         <= ~reg_mapped;
            clear_interrupt18 <= is_stat;
          end else begin
            rd_cnt <= rd_cnt - 2'd1;
          end
        end
        ST_WR_ACC, ST_RD_DONE: state <= ST_IDLE;
        default:               state <= ST_IDLE;
      endcase
    end
  end

  assign clk_ctrl_reg_sel18  = strb_p1[0];
  assign cntr_ctrl_reg_sel18 = strb_p1[1];
  assign interval_reg_sel18  = strb_p1[2];
  assign match_1_reg_sel18   = strb_p1[3];
  assign match_2_reg_sel18   = strb_p1[4];
  assign match_3_reg_sel18   = strb_p1[5];
  assign intr_en_reg_sel18   = strb_p1[6];

  a_one_strobe: assert property (@(posedge pclk18) $onehot0(strb_p1));

endmodule
